// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared types and constants for the two-input round-robin packet arbiter:
// FSM state encoding, mux select constants and the grant decode helper.
package mux2_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_e;

  localparam logic SEL_IN0 = 1'b0;
  localparam logic SEL_IN1 = 1'b1;

  function automatic logic [1:0] onehot_gnt(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// Bundle of the two requester streams, the shared output stream and the
// arbiter status signals (select, grant, grant counters, debug state).
interface mux2_rr_arbiter_if
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);

  // Handshake: a beat moves on a rising edge where valid and ready are both
  // high; the sender holds valid, data and last stable until that edge.
  logic             in0_valid;
  logic [WIDTH-1:0] in0_data;
  logic             in0_last;
  logic             in0_ready;
  logic             in1_valid;
  logic [WIDTH-1:0] in1_data;
  logic             in1_last;
  logic             in1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_ready;
  logic             sel;
  logic [1:0]       gnt;
  logic [CNT_W-1:0] gnt_cnt0;
  logic [CNT_W-1:0] gnt_cnt1;
  arb_state_e       dbg_state;

  modport master (
    output in0_valid, in0_data, in0_last, in1_valid, in1_data, in1_last, out_ready,
    input  in0_ready, in1_ready, out_valid, out_data, out_last,
    input  sel, gnt, gnt_cnt0, gnt_cnt1, dbg_state
  );

  modport slave (
    input  in0_valid, in0_data, in0_last, in1_valid, in1_data, in1_last, out_ready,
    output in0_ready, in1_ready, out_valid, out_data, out_last,
    output sel, gnt, gnt_cnt0, gnt_cnt1, dbg_state
  );

endinterface

// File: rtl/mux2_datapath.sv
// Gate-level W-bit 2:1 multiplexer; sel_i=0 passes a_i, sel_i=1 passes b_i.
module mux2_datapath #(
  parameter int W = 9
) (
  input  logic         sel_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);

  wire sel_n;

  not u_inv (sel_n, sel_i);

  for (genvar i = 0; i < W; i++) begin : g_bit
    wire a_g;
    wire b_g;
    and u_and_a (a_g, a_i[i], sel_n);
    and u_and_b (b_g, b_i[i], sel_i);
    or  u_or    (y_o[i], a_g, b_g);
  end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter holding a grant for a whole packet over a 2:1 mux.
// Optional per-requester grant counters are built when ARB_GRANT_CNT_EN is defined.
module mux2_rr_arbiter
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  mux2_rr_arbiter_if.slave  bus
);

  arb_state_e state_q, state_d;
  logic       sel_q, sel_d;
  logic [1:0] gnt_q, gnt_d;
  logic       rr_ptr_q, rr_ptr_d;
  logic       grant_in1;
  logic       end0, end1;

  assign end0 = bus.in0_valid & bus.out_ready & bus.in0_last;
  assign end1 = bus.in1_valid & bus.out_ready & bus.in1_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= SEL_IN0;
      gnt_q    <= 2'b00;
      rr_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // On a tie rr_ptr names the winner; it always points away from the last winner.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    gnt_d     = gnt_q;
    rr_ptr_d  = rr_ptr_q;
    grant_in1 = bus.in1_valid & (~bus.in0_valid | rr_ptr_q);
    case (state_q)
      ST_IDLE: begin
        if (bus.in0_valid | bus.in1_valid) begin
          state_d = grant_in1 ? ST_GNT1 : ST_GNT0;
          sel_d   = grant_in1 ? SEL_IN1 : SEL_IN0;
          gnt_d   = onehot_gnt(grant_in1);
        end
      end
      ST_GNT0: begin
        if (end0) begin
          state_d  = ST_IDLE;
          gnt_d    = 2'b00;
          rr_ptr_d = 1'b1;
        end
      end
      ST_GNT1: begin
        if (end1) begin
          state_d  = ST_IDLE;
          gnt_d    = 2'b00;
          rr_ptr_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_comb begin
    bus.out_valid = 1'b0;
    bus.in0_ready = 1'b0;
    bus.in1_ready = 1'b0;
    case (state_q)
      ST_GNT0: begin
        bus.out_valid = bus.in0_valid;
        bus.in0_ready = bus.out_ready;
      end
      ST_GNT1: begin
        bus.out_valid = bus.in1_valid;
        bus.in1_ready = bus.out_ready;
      end
      default: ;
    endcase
  end

  assign bus.sel       = sel_q;
  assign bus.gnt       = gnt_q;
  assign bus.dbg_state = state_q;

  mux2_datapath #(.W(WIDTH + 1)) u_datapath (
    .sel_i (sel_q),
    .a_i   ({bus.in0_last, bus.in0_data}),
    .b_i   ({bus.in1_last, bus.in1_data}),
    .y_o   ({bus.out_last, bus.out_data})
  );

`ifdef ARB_GRANT_CNT_EN
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (state_q == ST_IDLE) begin
      if (state_d == ST_GNT0) cnt0_q <= cnt0_q + 1'b1;
      if (state_d == ST_GNT1) cnt1_q <= cnt1_q + 1'b1;
    end
  end

  assign bus.gnt_cnt0 = cnt0_q;
  assign bus.gnt_cnt1 = cnt1_q;
`else
  assign bus.gnt_cnt0 = '0;
  assign bus.gnt_cnt1 = '0;
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Randomized bench for mux2_rr_arbiter: per-source expected beat queues and a
// packet-level arbitration model checked by a negedge monitor.
module tb_mux2_rr_arbiter;
  import mux2_rr_arbiter_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux2_rr_arbiter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  mux2_rr_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [WIDTH:0] exp_q0[$];
  logic [WIDTH:0] exp_q1[$];

  // Model: owner is -1 when nobody holds the output, else the granted source.
  int owner = -1;
  int ptr = 0;
  int model_cnt0 = 0;
  int model_cnt1 = 0;
  bit mon_en = 1'b0;
  bit rdy_rand = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int s, input logic v, input logic [WIDTH-1:0] d, input logic l);
    if (s == 0) begin
      bus.in0_valid = v; bus.in0_data = d; bus.in0_last = l;
    end else begin
      bus.in1_valid = v; bus.in1_data = d; bus.in1_last = l;
    end
  endtask

  task automatic wait_accept(input int s);
    int  cyc;
    bit  acc;
    cyc = 0;
    acc = 1'b0;
    while (!acc) begin
      @(negedge clk);
      acc = (s == 0) ? bus.in0_ready : bus.in1_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (!acc && cyc > 500) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout src%0d: no ready after %0d cycles, required acceptance", s, cyc);
        break;
      end
    end
  endtask

  task automatic send_pkt(input int s, input int len, input int gap_max);
    logic [WIDTH-1:0] d;
    logic             l;
    int               g;
    for (int b = 0; b < len; b++) begin
      d = WIDTH'($urandom_range(0, 255));
      l = (b == len - 1);
      if (s == 0) exp_q0.push_back({l, d});
      else        exp_q1.push_back({l, d});
      drive(s, 1'b1, d, l);
      wait_accept(s);
      if (!l && gap_max > 0) begin
        g = $urandom_range(0, gap_max);
        if (g > 0) begin
          drive(s, 1'b0, d, l);
          repeat (g) begin @(posedge clk); #1; end
        end
      end
    end
    drive(s, 1'b0, '0, 1'b0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) bus.out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: expectations come from owner/ptr, then the model advances.
  initial begin
    logic       v0, v1, rdy, e_val, e_r0, e_r1, got_last;
    logic [1:0] e_gnt;
    logic [WIDTH:0] beat;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        v0 = bus.in0_valid; v1 = bus.in1_valid; rdy = bus.out_ready;
        e_gnt = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
        e_val = (owner == 0) ? v0 : (owner == 1) ? v1 : 1'b0;
        e_r0  = (owner == 0) && rdy;
        e_r1  = (owner == 1) && rdy;
        check("gnt", 32'(bus.gnt), 32'(e_gnt));
        check("out_valid", 32'(bus.out_valid), 32'(e_val));
        check("in0_ready", 32'(bus.in0_ready), 32'(e_r0));
        check("in1_ready", 32'(bus.in1_ready), 32'(e_r1));
        check("state", 32'(bus.dbg_state), 32'(owner + 1));
        if (owner >= 0) check("sel", 32'(bus.sel), 32'(owner));
        if (owner >= 0 && e_val && rdy) begin
          got_last = bus.out_last;
          if ((owner == 0 && exp_q0.size() == 0) || (owner == 1 && exp_q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL out_beat: got 0x%0h from src%0d, expected no beat (queue empty)",
                     {bus.out_last, bus.out_data}, owner);
          end else begin
            beat = (owner == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check("out_beat", 32'({bus.out_last, bus.out_data}), 32'(beat));
            got_last = beat[WIDTH];
          end
          if (got_last) begin
            ptr = (owner == 0) ? 1 : 0;
            owner = -1;
          end
        end else if (owner < 0 && (v0 || v1)) begin
          owner = (v0 && v1) ? ptr : (v0 ? 0 : 1);
          if (owner == 0) model_cnt0++;
          else            model_cnt1++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_c0, exp_c1;
    rst_n = 1'b0;
    bus.in0_valid = 1'b0; bus.in0_data = 8'hA5; bus.in0_last = 1'b0;
    bus.in1_valid = 1'b0; bus.in1_data = 8'h5A; bus.in1_last = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in0_ready", 32'(bus.in0_ready), 32'd0);
    check("rst_in1_ready", 32'(bus.in1_ready), 32'd0);
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_sel", 32'(bus.sel), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'hA5);
    check("rst_cnt0", 32'(bus.gnt_cnt0), 32'd0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    bus.out_ready = 1'b1;
    repeat (10) begin @(posedge clk); #1; end

    // Single 3-beat in0 packet, then a simultaneous request from both sides.
    send_pkt(0, 3, 0);
    repeat (2) begin @(posedge clk); #1; end
    fork
      begin send_pkt(0, 2, 0); send_pkt(0, 2, 0); end
      send_pkt(1, 2, 0);
    join

    rdy_rand = 1'b1;
    fork
      repeat (25) begin
        send_pkt(0, $urandom_range(1, 4), 2);
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
      repeat (25) begin
        send_pkt(1, $urandom_range(1, 4), 2);
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
    join
    rdy_rand = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;

    repeat (17) send_pkt(0, 1, 0);
    repeat (3) begin @(posedge clk); #1; end

`ifdef ARB_GRANT_CNT_EN
    exp_c0 = 32'(model_cnt0 % (1 << CNT_W));
    exp_c1 = 32'(model_cnt1 % (1 << CNT_W));
`else
    exp_c0 = 32'd0;
    exp_c1 = 32'd0;
`endif
    @(negedge clk);
    check("gnt_cnt0", 32'(bus.gnt_cnt0), exp_c0);
    check("gnt_cnt1", 32'(bus.gnt_cnt1), exp_c1);
    check("q0_drained", 32'(exp_q0.size()), 32'd0);
    check("q1_drained", 32'(exp_q1.size()), 32'd0);

    // Reset in the middle of a 4-beat in1 packet, then a fresh tie.
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    drive(1, 1'b1, 8'h11, 1'b0);
    wait_accept(1);
    drive(1, 1'b1, 8'h22, 1'b0);
    bus.in0_data = 8'h77;
    @(negedge clk);
    check("mid_out_data", 32'(bus.out_data), 32'h22);
    check("mid_in1_ready", 32'(bus.in1_ready), 32'd1);
    check("mid_gnt", 32'(bus.gnt), 32'h2);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_in1_ready", 32'(bus.in1_ready), 32'd0);
    check("abort_gnt", 32'(bus.gnt), 32'd0);
    check("abort_sel", 32'(bus.sel), 32'd0);
    check("abort_out_data", 32'(bus.out_data), 32'h77);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(0, 1'b1, 8'h30, 1'b1);
    drive(1, 1'b1, 8'h40, 1'b1);
    @(negedge clk);
    check("rearb_idle_gnt", 32'(bus.gnt), 32'd0);
    check("rearb_idle_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("rearb_gnt", 32'(bus.gnt), 32'h1);
    check("rearb_out_data", 32'(bus.out_data), 32'h30);
    check("rearb_in0_ready", 32'(bus.in0_ready), 32'd1);
    check("rearb_in1_ready", 32'(bus.in1_ready), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
